// File: rtl/internal_register.sv
// ----------------------------------------------------------------------------
// internal_register
//   8 x 16-bit general-purpose register bank: one write port, two registered
//   read ports (operand A / operand B), single clock.
//
// Ports
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset; clears all registers and outputs
//   enable   : block enable; gates writes and read-output updates
//   wr_en    : write enable (only effective with enable=1)
//   rd_adrs  : write address
//   ra_adrs  : read port A address
//   rb_adrs  : read port B address
//   data_in  : write data
//   ra_out   : registered read data A (1-cycle latency)
//   rb_out   : registered read data B (1-cycle latency)
// ----------------------------------------------------------------------------
module internal_register #(
    parameter int NUM_OF_REGITER    = 8,
    parameter int WIDTH_OF_REGISTER = 16,
    parameter int WIDTH_OF_ADDR     = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         wr_en,
    input  logic [WIDTH_OF_ADDR-1:0]     rd_adrs,
    input  logic [WIDTH_OF_ADDR-1:0]     ra_adrs,
    input  logic [WIDTH_OF_ADDR-1:0]     rb_adrs,
    input  logic [WIDTH_OF_REGISTER-1:0] data_in,
    output logic [WIDTH_OF_REGISTER-1:0] ra_out,
    output logic [WIDTH_OF_REGISTER-1:0] rb_out
);

    logic [NUM_OF_REGITER-1:0][WIDTH_OF_REGISTER-1:0] regs;
    logic                                             wr;
    logic [WIDTH_OF_REGISTER-1:0]                     ra_nxt;
    logic [WIDTH_OF_REGISTER-1:0]                     rb_nxt;

    assign wr = enable & wr_en;

    // One always_ff per entry so each register only sees its own decode.
    for (genvar i = 0; i < NUM_OF_REGITER; i++) begin : g_reg
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                regs[i] <= '0;
            else if (wr && (rd_adrs == WIDTH_OF_ADDR'(i)))
                regs[i] <= data_in;
        end
    end

    // Write-first: a read of the address being written this edge returns the
    // new data rather than the stale register contents.
    always_comb begin
        ra_nxt = regs[ra_adrs];
        rb_nxt = regs[rb_adrs];
        if (wr && (ra_adrs == rd_adrs)) ra_nxt = data_in;
        if (wr && (rb_adrs == rd_adrs)) rb_nxt = data_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ra_out <= '0;
            rb_out <= '0;
        end else if (enable) begin
            ra_out <= ra_nxt;
            rb_out <= rb_nxt;
        end
    end

endmodule

// File: tb/tb_internal_register.sv
module tb_internal_register;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        wr_en;
    logic [2:0]  rd_adrs, ra_adrs, rb_adrs;
    logic [15:0] data_in;
    logic [15:0] ra_out, rb_out;

    int total = 0;
    int bad   = 0;

    internal_register #(
        .NUM_OF_REGITER   (8),
        .WIDTH_OF_REGISTER(16),
        .WIDTH_OF_ADDR    (3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (enable),
        .wr_en  (wr_en),
        .rd_adrs(rd_adrs),
        .ra_adrs(ra_adrs),
        .rb_adrs(rb_adrs),
        .data_in(data_in),
        .ra_out (ra_out),
        .rb_out (rb_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        we;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] din;
        logic [15:0] xa;
        logic [15:0] xb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic we, input logic [2:0] rd,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [15:0] din, input logic [15:0] xa,
                                input logic [15:0] xb);
        vec_t v;
        v.en = en; v.we = we; v.rd = rd; v.ra = ra; v.rb = rb;
        v.din = din; v.xa = xa; v.xb = xb;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] din);
        enable = en; wr_en = we; rd_adrs = rd; ra_adrs = ra; rb_adrs = rb; data_in = din;
    endtask

    // Drive on the falling edge, sample 1ns after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clock);
        drive(v.en, v.we, v.rd, v.ra, v.rb, v.din);
        @(posedge clock);
        #1;
        check({tag, ".ra"}, ra_out, v.xa);
        check({tag, ".rb"}, rb_out, v.xb);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);

        // Reset held with clock running and random inputs: outputs stay 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1'b1, 1'b1, 3'($urandom_range(7)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 16'($urandom));
            @(posedge clock);
            #1;
            check("rst_hold.ra", ra_out, 16'h0);
            check("rst_hold.rb", rb_out, 16'h0);
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
        reset_n = 1'b1;

        // Post-reset: every register reads 0.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 0, 3'(i), 3'(7 - i), 16'h0, 16'h0, 16'h0));
        // Fill reg[i] = 32-i while reading reg0; first cycle hits the bypass.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 3'(i), 0, 0, 16'(32 - i), 16'h0020, 16'h0020));
        // Read back pairs (i, i+4).
        tbl.push_back(mk(1, 0, 0, 0, 4, 16'h0, 16'h0020, 16'h001C));
        tbl.push_back(mk(1, 0, 0, 1, 5, 16'h0, 16'h001F, 16'h001B));
        tbl.push_back(mk(1, 0, 0, 2, 6, 16'h0, 16'h001E, 16'h001A));
        tbl.push_back(mk(1, 0, 0, 3, 7, 16'h0, 16'h001D, 16'h0019));
        // enable=0: outputs hold, write to reg2 dropped.
        tbl.push_back(mk(0, 1, 2, 6, 0, 16'hBEEF, 16'h001D, 16'h0019));
        tbl.push_back(mk(0, 1, 2, 2, 2, 16'hBEEF, 16'h001D, 16'h0019));
        tbl.push_back(mk(1, 0, 0, 2, 2, 16'h0, 16'h001E, 16'h001E));
        // Bypass on both ports, then plain read of reg5.
        tbl.push_back(mk(1, 1, 5, 5, 5, 16'hA5A5, 16'hA5A5, 16'hA5A5));
        tbl.push_back(mk(1, 0, 0, 5, 1, 16'h0, 16'hA5A5, 16'h001F));
        // Bypass on port A only; port B reads an unrelated register.
        tbl.push_back(mk(1, 1, 6, 6, 0, 16'h1111, 16'h1111, 16'h0020));
        tbl.push_back(mk(1, 0, 0, 7, 6, 16'h0, 16'h0019, 16'h1111));

        foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

        // Mid-operation async reset while writing 0x1234 to reg3.
        @(negedge clock);
        drive(1'b1, 1'b1, 3'd3, 3'd3, 3'd3, 16'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.ra", ra_out, 16'h0);
        check("async_rst.rb", rb_out, 16'h0);
        @(posedge clock);
        #1;
        check("rst_edge.ra", ra_out, 16'h0);
        check("rst_edge.rb", rb_out, 16'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
        reset_n = 1'b1;

        // First edge after release is a normal write; reg3 and others read 0.
        apply(mk(1, 1, 7, 3, 0, 16'h4321, 16'h0, 16'h0), "post_rel_wr");
        for (int i = 0; i < 7; i++)
            apply(mk(1, 0, 0, 3'(i), 3'(6 - i), 16'h0, 16'h0, 16'h0),
                  $sformatf("post_rel%0d", i));
        apply(mk(1, 0, 0, 7, 3, 16'h0, 16'h4321, 16'h0), "post_rel_r7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
